// File: rtl/sram_controller.sv
// Sequences 32-bit pipeline loads/stores onto a 16-bit asynchronous SRAM as two
// half-word accesses (low half first), padded to ACCESS_CYCLES cycles per access.
module sram_controller #(
    parameter int          ACCESS_CYCLES = 6,
    parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N,
    output logic [2:0]  dbg_state
);

    // Handshake: rd_en/wr_en are held by the requester until ready is seen high;
    // ready is high in IDLE with no request, and in the single DONE cycle.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOW  = 3'd1,
        S_HIGH = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam int CNT_W = $clog2(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((ACCESS_CYCLES > 4) ? ACCESS_CYCLES - 5 : 0);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [16:0]        word_q, word_d;
    logic [15:0]        wdata_hi_q, wdata_hi_d;
    logic               is_wr_q, is_wr_d;
    logic [31:0]        read_data_q, read_data_d;
    logic [17:0]        sram_addr_q, sram_addr_d;
    logic               we_n_q, we_n_d;
    logic               dq_oe_q, dq_oe_d;
    logic [15:0]        dq_out_q, dq_out_d;

    logic               req;
    logic [18:0]        offset;
    logic [16:0]        word_in;
    logic               unused_addr_bits;

    assign req     = rd_en | wr_en;
    // Only bits [18:2] of the wrapped difference matter, so a 19-bit subtract suffices.
    assign offset  = address[18:0] - BASE_ADDR[18:0];
    assign word_in = offset[18:2];
    assign unused_addr_bits = ^{address[31:19], offset[1:0]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        wdata_hi_d  = wdata_hi_q;
        is_wr_d     = is_wr_q;
        read_data_d = read_data_q;
        sram_addr_d = sram_addr_q;
        we_n_d      = 1'b1;
        dq_oe_d     = 1'b0;
        dq_out_d    = dq_out_q;
        ready       = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready = ~req;
                if (req) begin
                    word_d      = word_in;
                    wdata_hi_d  = write_data[31:16];
                    is_wr_d     = wr_en;
                    sram_addr_d = {word_in, 1'b0};
                    we_n_d      = ~wr_en;
                    dq_oe_d     = wr_en;
                    dq_out_d    = write_data[15:0];
                    state_d     = S_LOW;
                end
            end
            S_LOW: begin
                if (!is_wr_q) read_data_d[15:0] = SRAM_DQ;
                sram_addr_d = {word_q, 1'b1};
                we_n_d      = ~is_wr_q;
                dq_oe_d     = is_wr_q;
                dq_out_d    = wdata_hi_q;
                state_d     = S_HIGH;
            end
            S_HIGH: begin
                if (!is_wr_q) read_data_d[31:16] = SRAM_DQ;
                cnt_d   = '0;
                state_d = (ACCESS_CYCLES == 4) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) state_d = S_DONE;
                else                    cnt_d   = cnt_q + CNT_W'(1);
            end
            S_DONE: begin
                ready   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            wdata_hi_q  <= '0;
            is_wr_q     <= 1'b0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            wdata_hi_q  <= wdata_hi_d;
            is_wr_q     <= is_wr_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
        end
    end

    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'bz;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;
    assign read_data = read_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: default-latency instance plus an ACCESS_CYCLES=4 instance,
// each wired to a behavioural asynchronous SRAM; results checked against a word-level model.
module tb_sram_controller;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // default instance
    logic        rst, wr_en, rd_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        ub_n, lb_n, ce_n, oe_n, we_n;
    wire  [2:0]  unused_dbg;

    // ACCESS_CYCLES = 4 instance
    logic        rst4, wr_en4, rd_en4;
    logic [31:0] address4, write_data4;
    logic [31:0] read_data4;
    logic        ready4;
    wire  [15:0] sram_dq4;
    logic [17:0] sram_addr4;
    logic        ub_n4, lb_n4, ce_n4, oe_n4, we_n4;
    wire  [2:0]  unused_dbg4;

    sram_controller dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(sram_dq),
        .SRAM_ADDR(sram_addr), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n),
        .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .dbg_state(unused_dbg)
    );

    sram_controller #(.ACCESS_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst4), .wr_en(wr_en4), .rd_en(rd_en4), .address(address4),
        .write_data(write_data4), .read_data(read_data4), .ready(ready4), .SRAM_DQ(sram_dq4),
        .SRAM_ADDR(sram_addr4), .SRAM_UB_N(ub_n4), .SRAM_LB_N(lb_n4), .SRAM_CE_N(ce_n4),
        .SRAM_OE_N(oe_n4), .SRAM_WE_N(we_n4), .dbg_state(unused_dbg4)
    );

    // Behavioural SRAMs: output enabled whenever not writing, write latched at the clock edge.
    logic [15:0] mem  [0:262143];
    logic [15:0] mem4 [0:262143];
    logic        pre_en = 1'b0;
    logic [17:0] pre_addr = '0;
    logic [15:0] pre_data = '0;

    assign sram_dq  = we_n  ? mem[sram_addr]   : 16'bz;
    assign sram_dq4 = we_n4 ? mem4[sram_addr4] : 16'bz;

    always @(posedge clk) begin
        if (!we_n)       mem[sram_addr] <= sram_dq;
        else if (pre_en) mem[pre_addr]  <= pre_data;
    end

    always @(posedge clk) begin
        if (!we_n4) mem4[sram_addr4] <= sram_dq4;
    end

    // Word-level reference: word index -> 32-bit value
    logic [31:0] model_mem [int];
    int          written_q [$];

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] off;
        off = a - 32'd1024;
        return int'((off >> 2) & 32'h1FFFF);
    endfunction

    task automatic preload(input logic [17:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Counts cycles from the request cycle (cycle 1) until ready is seen; -1 on timeout.
    task automatic wait_ready(input bit sel, output int cycles, output logic [31:0] rdata,
                              output bit we_low);
        cycles = -1; rdata = '0; we_low = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (sel ? !we_n4 : !we_n) we_low = 1'b1;
            if (sel ? ready4 : ready) begin
                cycles = c + 1;
                rdata  = sel ? read_data4 : read_data;
                break;
            end
        end
    endtask

    task automatic do_access(input bit sel, input bit wr, input bit rd, input logic [31:0] a,
                             input logic [31:0] d, output int cycles,
                             output logic [31:0] rdata, output bit we_low);
        @(posedge clk); #1;
        if (sel) begin wr_en4 = wr; rd_en4 = rd; address4 = a; write_data4 = d; end
        else     begin wr_en  = wr; rd_en  = rd; address  = a; write_data  = d; end
        wait_ready(sel, cycles, rdata, we_low);
        @(posedge clk); #1;
        if (sel) begin wr_en4 = 1'b0; rd_en4 = 1'b0; end
        else     begin wr_en  = 1'b0; rd_en  = 1'b0; end
    endtask

    task automatic test_reset;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        rst4 = 1'b1; wr_en4 = 1'b0; rd_en4 = 1'b0; address4 = '0; write_data4 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++; if (read_data !== 32'h0) begin n_bad++; $display("FAIL reset_read_data: got %h want 0", read_data); end
        n_cmp++; if (we_n !== 1'b1) begin n_bad++; $display("FAIL reset_we_n: got %b want 1", we_n); end
        n_cmp++; if (sram_addr !== 18'h0) begin n_bad++; $display("FAIL reset_sram_addr: got %h want 0", sram_addr); end
        n_cmp++; if ({ub_n, lb_n, ce_n, oe_n} !== 4'b0000) begin n_bad++; $display("FAIL reset_ties: got %b want 0000", {ub_n, lb_n, ce_n, oe_n}); end
        rd_en = 1'b1;
        #1;
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_req: got %b want 0", ready); end
        @(posedge clk); #1;
        rd_en = 1'b0; rst = 1'b0; rst4 = 1'b0;
    endtask

    task automatic test_write_layout;
        int cyc; logic [31:0] rd; bit wl;
        do_access(0, 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, cyc, rd, wl);
        model_mem[0] = 32'hDEADBEEF; written_q.push_back(0);
        n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL write_latency: got %0d want 6", cyc); end
        n_cmp++; if (mem[0] !== 16'hBEEF) begin n_bad++; $display("FAIL write_low_half: got %h want beef", mem[0]); end
        n_cmp++; if (mem[1] !== 16'hDEAD) begin n_bad++; $display("FAIL write_high_half: got %h want dead", mem[1]); end
        n_cmp++; if (wl !== 1'b1) begin n_bad++; $display("FAIL write_strobe: got %b want 1", wl); end
    endtask

    task automatic test_read_back;
        int cyc; logic [31:0] rd; bit wl;
        preload(18'd2, 16'h5678);
        preload(18'd3, 16'h1234);
        model_mem[1] = 32'h12345678; written_q.push_back(1);
        do_access(0, 1'b0, 1'b1, 32'd1028, 32'h0, cyc, rd, wl);
        n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL read_latency: got %0d want 6", cyc); end
        n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL read_data: got %h want 12345678", rd); end
        n_cmp++; if (wl !== 1'b0) begin n_bad++; $display("FAIL read_no_strobe: got %b want 0", wl); end
    endtask

    task automatic test_idle;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++; if (ready !== 1'b1 || we_n !== 1'b1) begin
                n_bad++; $display("FAIL idle_cycle_%0d: ready=%b we_n=%b want 1/1", i, ready, we_n);
            end
        end
    endtask

    task automatic test_both_asserted;
        int cyc; logic [31:0] rd; bit wl;
        logic [31:0] d;
        d = $urandom;
        do_access(0, 1'b1, 1'b1, 32'd1036, d, cyc, rd, wl);
        model_mem[3] = d; written_q.push_back(3);
        n_cmp++; if (wl !== 1'b1) begin n_bad++; $display("FAIL both_is_write: got %b want 1", wl); end
        n_cmp++; if ({mem[7], mem[6]} !== d) begin n_bad++; $display("FAIL both_layout: got %h want %h", {mem[7], mem[6]}, d); end
        do_access(0, 1'b0, 1'b1, 32'd1036, 32'h0, cyc, rd, wl);
        n_cmp++; if (rd !== d) begin n_bad++; $display("FAIL both_readback: got %h want %h", rd, d); end
    endtask

    task automatic test_back_to_back;
        int c1, c2, c3; logic [31:0] r1, r2, r3; bit w1, w2, w3;
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1032; write_data = 32'h11112222;
        wait_ready(0, c1, r1, w1);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b1;
        wait_ready(0, c2, r2, w2);
        @(posedge clk); #1;
        wait_ready(0, c3, r3, w3);
        @(posedge clk); #1;
        rd_en = 1'b0;
        model_mem[2] = 32'h11112222; written_q.push_back(2);
        n_cmp++; if (c1 !== 6) begin n_bad++; $display("FAIL b2b_write_latency: got %0d want 6", c1); end
        n_cmp++; if (c2 !== 6) begin n_bad++; $display("FAIL b2b_read_latency: got %0d want 6", c2); end
        n_cmp++; if (r2 !== 32'h11112222) begin n_bad++; $display("FAIL b2b_read_data: got %h want 11112222", r2); end
        n_cmp++; if (c3 !== 6 || r3 !== 32'h11112222) begin
            n_bad++; $display("FAIL b2b_held_reissue: got %0d/%h want 6/11112222", c3, r3);
        end
    endtask

    task automatic test_reset_mid_write;
        int cyc; logic [31:0] rd; bit wl;
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1600; write_data = $urandom;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL abort_no_ready: got %b want 0", ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (we_n !== 1'b1) begin n_bad++; $display("FAIL abort_we_n: got %b want 1", we_n); end
        n_cmp++; if (read_data !== 32'h0) begin n_bad++; $display("FAIL abort_read_data: got %h want 0", read_data); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL abort_idle_ready: got %b want 1", ready); end
        do_access(0, 1'b0, 1'b1, 32'd1024, 32'h0, cyc, rd, wl);
        n_cmp++; if (cyc !== 6 || rd !== model_mem[0]) begin
            n_bad++; $display("FAIL abort_then_read: got %0d/%h want 6/%h", cyc, rd, model_mem[0]);
        end
    endtask

    task automatic test_wrap;
        int cyc; logic [31:0] rd; bit wl;
        logic [31:0] d;
        d = $urandom;
        do_access(0, 1'b1, 1'b0, 32'd1020, d, cyc, rd, wl);
        n_cmp++; if ({mem[18'h3FFFF], mem[18'h3FFFE]} !== d) begin
            n_bad++; $display("FAIL wrap_layout: got %h want %h", {mem[18'h3FFFF], mem[18'h3FFFE]}, d);
        end
    endtask

    task automatic test_random;
        int cyc; logic [31:0] rd; bit wl;
        logic [31:0] d, a;
        int w, lo;
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(1) == 1) begin
                w = $urandom_range(63);
                a = 32'd1024 + 32'(w) * 4;
                d = $urandom;
                do_access(0, 1'b1, 1'b0, a, d, cyc, rd, wl);
                if (!model_mem.exists(w)) written_q.push_back(w);
                model_mem[w] = d;
                lo = word_of(a) * 2;
                n_cmp++; if ({mem[lo + 1], mem[lo]} !== d || wl !== 1'b1) begin
                    n_bad++; $display("FAIL rand_write_%0d: got %h we=%b want %h we=1", i, {mem[lo + 1], mem[lo]}, wl, d);
                end
            end else begin
                w = written_q[$urandom_range(written_q.size() - 1)];
                a = 32'd1024 + 32'(w) * 4 + 32'($urandom_range(3));
                do_access(0, 1'b0, 1'b1, a, $urandom, cyc, rd, wl);
                n_cmp++; if (rd !== model_mem[w] || wl !== 1'b0) begin
                    n_bad++; $display("FAIL rand_read_%0d: got %h we=%b want %h we=0", i, rd, wl, model_mem[w]);
                end
            end
            n_cmp++; if (cyc !== 6) begin n_bad++; $display("FAIL rand_latency_%0d: got %0d want 6", i, cyc); end
        end
    endtask

    task automatic test_param_sweep;
        int cyc; logic [31:0] rd; bit wl;
        logic [31:0] d;
        d = $urandom;
        do_access(1, 1'b1, 1'b0, 32'd1032, d, cyc, rd, wl);
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL p4_write_latency: got %0d want 4", cyc); end
        n_cmp++; if ({mem4[5], mem4[4]} !== d) begin n_bad++; $display("FAIL p4_layout: got %h want %h", {mem4[5], mem4[4]}, d); end
        do_access(1, 1'b0, 1'b1, 32'd1032, 32'h0, cyc, rd, wl);
        n_cmp++; if (cyc !== 4) begin n_bad++; $display("FAIL p4_read_latency: got %0d want 4", cyc); end
        n_cmp++; if (rd !== d) begin n_bad++; $display("FAIL p4_read_data: got %h want %h", rd, d); end
        n_cmp++; if ({ub_n4, lb_n4, ce_n4, oe_n4} !== 4'b0000) begin n_bad++; $display("FAIL p4_ties: got %b want 0000", {ub_n4, lb_n4, ce_n4, oe_n4}); end
    endtask

    initial begin
        test_reset;
        test_write_layout;
        test_read_back;
        test_idle;
        test_both_asserted;
        test_back_to_back;
        test_reset_mid_write;
        test_wrap;
        test_random;
        test_param_sweep;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Sequences 32-bit load/store requests from the ARM pipeline's memory stage onto the DE2 board's 16-bit asynchronous SRAM. Each word access is split into two half-word accesses, low half first, and padded to a fixed latency. `ready` is the pipeline's freeze source: the pipeline stalls while `ready` is low. The block sits between the MEM stage and the `SRAM_*` board pins in the top level.

## Interface
- `ACCESS_CYCLES`, 6: total cycles per access, counted from the request cycle through the `ready` cycle inclusive; legal values are ≥ 4.
- `BASE_ADDR`, 1024: byte address that maps to SRAM word 0.
- `clk`  in  1  system clock (`CLOCK_50` domain).
- `rst`  in  1  reset; synchronous, active-high.
- `wr_en`  in  1  store request; held by the requester until `ready`.
- `rd_en`  in  1  load request; held by the requester until `ready`.
- `address`  in  32  byte address; word-aligned (bits [1:0] ignored).
- `write_data`  in  32  store data.
- `read_data`  out  32  load data; registered.
- `ready`  out  1  high = no access pending or access completing this cycle.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N`  out  1 each  tied to 0.
- `SRAM_WE_N`  out  1  write strobe, active low.

## Operation
- Word index: `word = (address - BASE_ADDR)[18:2]`, 17 bits. Half addresses are `{word,1'b0}` for the low half and `{word,1'b1}` for the high half. Subtraction wraps mod 2^32; no range check.
- States: IDLE, LOW, HIGH, WAIT, DONE.
- **IDLE**
  - `req = rd_en | wr_en`.
  - If `req`: capture `word`, `write_data`, `is_wr = wr_en` (write wins if both are asserted), then go to LOW.
- **LOW**
  - `SRAM_ADDR = {word,0}`.
  - Write: `SRAM_WE_N = 0` and DQ driven with `wdata[15:0]`.
  - Read: DQ is Z; DQ is latched into `read_data[15:0]` at the clock edge.
  - Next state: HIGH.
- **HIGH**
  - Same as LOW using `{word,1}` and bits [31:16].
  - Next state: WAIT, or DONE when `ACCESS_CYCLES == 4`.
- **WAIT**
  - Counter counts `ACCESS_CYCLES - 4` cycles, then goes to DONE.
  - `SRAM_WE_N = 1`, DQ is Z.
- **DONE**
  - `ready = 1`, `read_data` valid.
  - Next state: IDLE unconditionally.
- **`ready` (combinational)**
  - IDLE: `ready = ~req`.
  - LOW, HIGH, WAIT: `ready = 0`.
  - DONE: `ready = 1`.
- Inputs that change after the IDLE capture are ignored until the next IDLE.
- `SRAM_DQ` is driven only in LOW/HIGH during writes; Z otherwise.
- Outside LOW/HIGH writes, `SRAM_WE_N = 1` and `SRAM_ADDR` holds its last value (0 after reset).
- Writes leave `read_data` unchanged.

## Timing
- Reset values:
  - state = IDLE, counter = 0;
  - `read_data = 0`, `SRAM_ADDR = 0`, `SRAM_WE_N = 1`, DQ = Z;
  - `ready = ~req`.
- Latency:
  - Request seen in cycle 0 → `ready` low in cycles 0 to `ACCESS_CYCLES-2`, high in cycle `ACCESS_CYCLES-1`.
  - Default: 5 stall cycles, `ready` in the 6th cycle.
- Back-to-back: the request is re-sampled in the IDLE cycle after DONE. A held request therefore starts a new access; the pipeline must have advanced on the `ready` edge.
- `rst` takes priority over everything, in every state. Reset mid-access aborts it: `WE_N` returns to 1 on the next edge and a partial SRAM write may remain. No `ready` pulse is generated for the aborted access.
- Read capture: SRAM data must settle within one 20 ns cycle of the `SRAM_ADDR` change.

## Test plan
- **Write layout:** `wr_en`, `address = 1024`, `write_data = 0xDEADBEEF` → SRAM[0] = 0xBEEF, SRAM[1] = 0xDEAD; `ready` low for exactly 5 cycles, then high 1 cycle.
- **Read back:** preload SRAM[2] = 0x5678, SRAM[3] = 0x1234; `rd_en`, `address = 1028` → `read_data = 0x12345678` in the `ready` cycle; `SRAM_WE_N` stays 1 and DQ is never driven.
- **Idle and both-asserted:**
  - No request for 20 cycles → `ready` = 1 throughout, `SRAM_WE_N` = 1.
  - `rd_en = wr_en = 1` → treated as a write.
- **Back-to-back:** write 0x11112222 @1032, then read @1032 held continuously → two 6-cycle accesses separated by exactly one IDLE cycle; read returns 0x11112222.
- **Reset mid-write:** `rst` asserted in the HIGH cycle → next cycle state is IDLE, `WE_N` = 1, DQ = Z, `read_data` = 0; a following read @1024 completes normally.
- **Parameter sweep:** `ACCESS_CYCLES = 4` → `ready` high on the 4th cycle.
